// File: rtl/mem_rd_return_buffer_pkg.sv
// Shared types and constants for the data-memory read return path.
package mem_rd_return_buffer_pkg;

  localparam int unsigned WORD_W              = 32;
  localparam int unsigned N_BANKS             = 16;
  localparam int unsigned DATA_MEM_RD_LATENCY = 2;
  localparam logic        RESET_STATE         = 1'b1;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_rd_return_fifo.sv
// One bank lane: in-flight read tracking, return FIFO, occupancy and read credit.
module rd_return_fifo
  import mem_rd_return_buffer_pkg::*;
#(
  parameter int unsigned RD_LATENCY = DATA_MEM_RD_LATENCY,
  parameter int unsigned FIFO_DEPTH = RD_LATENCY + 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rd_req_i,
  input  logic  pop_i,
  input  word_t rdata_i,
  output logic  rd_ready_o,
  output logic  mem_rd_en_o,
  output logic  arrive_o,
  output logic  vld_o,
  output word_t data_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [OW-1:0] DEPTH_OCC = OW'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CR  = CW'(FIFO_DEPTH);

  logic [RD_LATENCY-1:0] sr_q, sr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;
  word_t                 head_q, head_d;
  word_t                 mem_q [FIFO_DEPTH];
  logic [CW-1:0]         credit_c;
  logic                  write_c, fifo_pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit counts in-flight reads plus buffered words; a same-cycle pop is not credited.
  always_comb begin
    credit_c = CW'(occ_q);
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      credit_c = credit_c + CW'(sr_q[i]);
    end
  end

  assign rd_ready_o  = (credit_c < DEPTH_CR);
  assign mem_rd_en_o = rd_req_i & rd_ready_o;
  assign arrive_o    = sr_q[RD_LATENCY-1];
  assign vld_o       = (occ_q != '0);
  assign data_o      = head_q;

  always_comb begin
    sr_d    = '0;
    sr_d[0] = mem_rd_en_o;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      sr_d[i] = sr_q[i-1];
    end
    fifo_pop_c = pop_i & vld_o;
    // A pop while empty is a bypass consume: the arriving word never enters storage.
    write_c    = arrive_o & ~(pop_i & ~vld_o);
    wr_ptr_d   = write_c    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = fifo_pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d      = occ_q + OW'(write_c) - OW'(fifo_pop_c);
    head_d     = head_q;
    if (occ_d != '0) begin
      head_d = (write_c && (wr_ptr_q == rd_ptr_d)) ? rdata_i : mem_q[rd_ptr_d];
    end else if (arrive_o) begin
      head_d = rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RESET_STATE) begin
      sr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      head_q   <= '0;
    end else begin
      sr_q     <= sr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write_c) begin
      mem_q[wr_ptr_q] <= rdata_i;
    end
  end

  a_no_arrival_when_full: assert property (@(posedge clk) disable iff (rst == RESET_STATE)
    !(arrive_o && (occ_q == DEPTH_OCC)));

endmodule

// File: rtl/mem_rd_return_buffer.sv
// Per-bank read issue and return buffering between data memory and the crossbar.
// Optional same-cycle bypass of empty lanes: define MEM_RD_BYPASS_EN.
module mem_rd_return_buffer
  import mem_rd_return_buffer_pkg::*;
#(
  parameter int unsigned N_BANKS    = mem_rd_return_buffer_pkg::N_BANKS,
  parameter int unsigned RD_LATENCY = DATA_MEM_RD_LATENCY,
  parameter int unsigned FIFO_DEPTH = RD_LATENCY + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_en,
  input  logic  [N_BANKS-1:0] rd_req,
  output logic  [N_BANKS-1:0] rd_ready,
  output logic  [N_BANKS-1:0] mem_rd_en,
  input  word_t [N_BANKS-1:0] mem_rdata,
  output word_t [N_BANKS-1:0] out_data,
  output logic  [N_BANKS-1:0] out_vld
);

`ifdef MEM_RD_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  for (genvar b = 0; b < int'(N_BANKS); b++) begin : g_lane
    logic  lane_vld, arrive, byp, vld, pop;
    word_t lane_data;

    rd_return_fifo #(
      .RD_LATENCY (RD_LATENCY),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .rd_req_i    (rd_req[b]),
      .pop_i       (pop),
      .rdata_i     (mem_rdata[b]),
      .rd_ready_o  (rd_ready[b]),
      .mem_rd_en_o (mem_rd_en[b]),
      .arrive_o    (arrive),
      .vld_o       (lane_vld),
      .data_o      (lane_data)
    );

    // Empty lane with an arriving word presents memory data directly.
    assign byp         = BYPASS & arrive & ~lane_vld;
    assign vld         = lane_vld | byp;
    assign pop         = vld & pipe_en;
    assign out_vld[b]  = vld;
    assign out_data[b] = byp ? mem_rdata[b] : lane_data;
  end

endmodule

// File: tb/tb_mem_rd_return_buffer.sv
// Directed bench for mem_rd_return_buffer with a fixed-latency memory model and per-bank scoreboard.
module tb_mem_rd_return_buffer;
  import mem_rd_return_buffer_pkg::*;

  localparam int unsigned NB = N_BANKS;
  localparam int unsigned L  = DATA_MEM_RD_LATENCY;
  localparam logic [NB-1:0] ALL = '1;
  localparam logic [NB-1:0] B0  = NB'(1);
  localparam logic [NB-1:0] B1  = NB'(2);
  localparam logic [NB-1:0] B3  = NB'(8);
  localparam logic [NB-1:0] B5  = NB'(32);

  logic              clk, rst, pipe_en;
  logic [NB-1:0]     rd_req, rd_ready, mem_rd_en, out_vld;
  word_t [NB-1:0]    mem_rdata, out_data;

  mem_rd_return_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_en   (pipe_en),
    .rd_req    (rd_req),
    .rd_ready  (rd_ready),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_vld   (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          pe;
    logic [NB-1:0] req;
    logic [NB-1:0] ready;
    logic [NB-1:0] rd_en;
    logic [NB-1:0] vld;
    int            bank;
    logic [31:0]   data;
    logic          chk;
  } vec_t;

  vec_t          tbl [18];
  logic [NB-1:0] pv [L];
  word_t         pd [L][NB];
  logic [NB-1:0] acc_prev;
  word_t         acc_data [NB];
  word_t         base [NB];
  int            acc_cnt [NB];
  int            dlv_cnt [NB];
  bit            mon_en;
  int            errors, checks, cyc;

  function automatic vec_t mk(input logic r, input logic pe, input logic [NB-1:0] req,
                              input logic [NB-1:0] ready, input logic [NB-1:0] rd_en,
                              input logic [NB-1:0] vld, input int bank,
                              input logic [31:0] data, input logic c);
    vec_t v;
    v.rst = r; v.pe = pe; v.req = req; v.ready = ready; v.rd_en = rd_en;
    v.vld = vld; v.bank = bank; v.data = data; v.chk = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock: advance the memory model, drive inputs, then sample and score outputs.
  task automatic step(input logic r, input logic pe, input logic [NB-1:0] req);
    @(posedge clk);
    for (int i = int'(L) - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      for (int b = 0; b < int'(NB); b++) pd[i][b] = pd[i-1][b];
    end
    pv[0] = acc_prev;
    for (int b = 0; b < int'(NB); b++) pd[0][b] = acc_data[b];
    #1;
    rst = r; pipe_en = pe; rd_req = req;
    for (int b = 0; b < int'(NB); b++) mem_rdata[b] = pv[L-1][b] ? pd[L-1][b] : 32'hDEAD_BEEF;
    #1;
    acc_prev = mem_rd_en;
    for (int b = 0; b < int'(NB); b++) begin
      if (mem_rd_en[b]) begin
        acc_data[b] = base[b] + 32'(acc_cnt[b]);
        acc_cnt[b]++;
      end
      if (mon_en && out_vld[b] && pipe_en) begin
        chk($sformatf("deliver.bank%0d", b), out_data[b], base[b] + 32'(dlv_cnt[b]));
        dlv_cnt[b]++;
      end
    end
    cyc++;
  endtask

  task automatic sb_clear();
    for (int b = 0; b < int'(NB); b++) begin
      acc_cnt[b] = 0;
      dlv_cnt[b] = 0;
      base[b]    = 32'(b) << 16;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    sb_clear();
  endtask

  function automatic bit all_done();
    for (int b = 0; b < int'(NB); b++) if (dlv_cnt[b] != acc_cnt[b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && !all_done(); k++) step(1'b0, 1'b1, '0);
    for (int b = 0; b < int'(NB); b++) begin
      chk($sformatf("%s.count.bank%0d", nm, b), 32'(dlv_cnt[b]), 32'(acc_cnt[b]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; mon_en = 1'b0;
    rst = 1'b1; pipe_en = 1'b0; rd_req = '0; acc_prev = '0;
    for (int i = 0; i < int'(L); i++) begin
      pv[i] = '0;
      for (int b = 0; b < int'(NB); b++) pd[i][b] = '0;
    end
    for (int b = 0; b < int'(NB); b++) begin
      mem_rdata[b] = '0;
      acc_data[b]  = '0;
    end
    sb_clear();
    base[3] = 32'hA5;
    base[0] = 32'h1;

    // Single read on bank 3, then a stall fill of bank 0.
    tbl[0]  = mk(1, 1, '0,  ALL, '0, '0, 3, 32'h0,  0);
    tbl[1]  = mk(0, 1, '0,  ALL, '0, '0, 3, 32'h0,  1);
    tbl[2]  = mk(0, 1, B3,  ALL, B3, '0, 3, 32'h0,  1);
    tbl[3]  = mk(0, 1, '0,  ALL, '0, '0, 3, 32'h0,  1);
`ifdef MEM_RD_BYPASS_EN
    tbl[4]  = mk(0, 1, '0,  ALL, '0, B3, 3, 32'hA5, 1);
    tbl[5]  = mk(0, 1, '0,  ALL, '0, '0, 3, 32'hA5, 1);
`else
    tbl[4]  = mk(0, 1, '0,  ALL, '0, '0, 3, 32'h0,  1);
    tbl[5]  = mk(0, 1, '0,  ALL, '0, B3, 3, 32'hA5, 1);
`endif
    tbl[6]  = mk(0, 1, '0,  ALL, '0, '0, 3, 32'hA5, 1);
    tbl[7]  = mk(0, 0, B0,  ALL, B0, '0, 0, 32'h0,  1);
    tbl[8]  = mk(0, 0, B0,  ALL, B0, '0, 0, 32'h0,  1);
`ifdef MEM_RD_BYPASS_EN
    tbl[9]  = mk(0, 0, B0,  ALL, B0, B0, 0, 32'h1,  1);
`else
    tbl[9]  = mk(0, 0, B0,  ALL, B0, '0, 0, 32'h0,  1);
`endif
    tbl[10] = mk(0, 0, B0, ~B0,  '0, B0, 0, 32'h1,  1);
    tbl[11] = mk(0, 0, B0, ~B0,  '0, B0, 0, 32'h1,  1);
    tbl[12] = mk(0, 0, B0, ~B0,  '0, B0, 0, 32'h1,  1);
    tbl[13] = mk(0, 0, B0, ~B0,  '0, B0, 0, 32'h1,  1);
    tbl[14] = mk(0, 1, '0, ~B0,  '0, B0, 0, 32'h1,  1);
    tbl[15] = mk(0, 1, '0,  ALL, '0, B0, 0, 32'h2,  1);
    tbl[16] = mk(0, 1, '0,  ALL, '0, B0, 0, 32'h3,  1);
    tbl[17] = mk(0, 1, '0,  ALL, '0, '0, 0, 32'h3,  1);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].pe, tbl[i].req);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d.rd_ready", i),  32'(rd_ready),  32'(tbl[i].ready));
        chk($sformatf("tbl%0d.mem_rd_en", i), 32'(mem_rd_en), 32'(tbl[i].rd_en));
        chk($sformatf("tbl%0d.out_vld", i),   32'(out_vld),   32'(tbl[i].vld));
        chk($sformatf("tbl%0d.out_data", i),  out_data[tbl[i].bank], tbl[i].data);
      end
    end

    // Reset while two reads on bank 5 are in flight.
    do_reset();
    step(1'b0, 1'b1, B5);
    chk("rstmid.rd_en", 32'(mem_rd_en), 32'(B5));
    step(1'b1, 1'b1, B5);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, '0);
      chk($sformatf("rstmid.rd_ready%0d", k), 32'(rd_ready), 32'(ALL));
      chk($sformatf("rstmid.out_vld%0d", k),  32'(out_vld),  32'h0);
    end
    chk("rstmid.out_data5", out_data[5], 32'h0);

    // Bank 0 full under stall while bank 1 still accepts.
    do_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, B0);
    chk("indep.acc0", 32'(acc_cnt[0]), 32'd3);
    step(1'b0, 1'b0, B1);
    chk("indep.ready0", 32'(rd_ready[0]), 32'd0);
    chk("indep.ready1", 32'(rd_ready[1]), 32'd1);
    chk("indep.rd_en",  32'(mem_rd_en),   32'(B1));
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0);
    chk("indep.vld", 32'(out_vld), 32'(B0 | B1));
    chk("indep.data1", out_data[1], 32'h0001_0000);
    drain("indep");

    // Streaming on all banks: order, completeness and throughput.
    do_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 100; k++) step(1'b0, 1'b1, ALL);
    for (int b = 0; b < int'(NB); b++) begin
      chk($sformatf("stream.tput.bank%0d(accepts=%0d)", b, acc_cnt[b]),
          32'(acc_cnt[b] * 3 >= 200), 32'd1);
`ifdef MEM_RD_BYPASS_EN
      chk($sformatf("stream.bypass_tput.bank%0d(accepts=%0d)", b, acc_cnt[b]),
          32'(acc_cnt[b] >= 98), 32'd1);
`endif
    end
    drain("stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
